paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_pkg.sv | 20 ++
 rtl/paddle_ctrl_tick_gen.sv | 29 ++
 rtl/paddle_ctrl.sv | 150 +++++++++++++++
 tb/tb_paddle_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and default motion constants for the paddle controller.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int unsigned DEF_STEP_SLOW   = 1;
    localparam int unsigned DEF_STEP_FAST   = 4;
    localparam int unsigned DEF_ACCEL_TICKS = 16;

endpackage

// File: rtl/paddle_ctrl_tick_gen.sv
// Movement tick divider: one-cycle pulse every TICK_DIV enabled clk cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: ticked left/right motion with slow->fast
// acceleration, edge clamping, load and pause.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int unsigned POS_W       = 10,
    parameter int unsigned TICK_DIV    = 250000,
    parameter int unsigned STEP_SLOW   = DEF_STEP_SLOW,
    parameter int unsigned STEP_FAST   = DEF_STEP_FAST,
    parameter int unsigned ACCEL_TICKS = DEF_ACCEL_TICKS,
    parameter int unsigned X_RESET     = 270
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             load,
    input  logic [POS_W-1:0] x_initial,
    input  logic             move_left,
    input  logic             move_right,
    input  logic [POS_W-1:0] screen_width,
    input  logic [POS_W-1:0] paddle_width,
    output logic [POS_W-1:0] x_pos,
    output logic             at_left,
    output logic             at_right,
    output logic             speed_fast
);

    if (STEP_SLOW < 1 || STEP_FAST < STEP_SLOW || TICK_DIV < 2) begin : g_param_check
        $error("paddle_ctrl: need STEP_FAST >= STEP_SLOW >= 1 and TICK_DIV >= 2");
    end

    localparam int unsigned HW = $clog2(ACCEL_TICKS + 2);
    localparam logic [POS_W-1:0] STEP_S = POS_W'(STEP_SLOW);
    localparam logic [POS_W-1:0] STEP_F = POS_W'(STEP_FAST);

    logic             tick;
    logic [POS_W-1:0] right_limit;
    logic [POS_W-1:0] x_nxt;
    logic [POS_W-1:0] step;
    logic [POS_W:0]   sum;
    state_t           state, state_nxt;
    dir_t             dir, dir_q, dir_nxt, mv_dir;
    logic [HW-1:0]    hold, hold_nxt;
    logic             fast_step;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (!pause),
        .clr  (load),
        .tick (tick)
    );

    assign right_limit = (paddle_width >= screen_width) ? '0 : screen_width - paddle_width;

    always_comb begin
        if (move_left && !move_right)      dir = DIR_LEFT;
        else if (move_right && !move_left) dir = DIR_RIGHT;
        else                               dir = DIR_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            dir_q      <= DIR_NONE;
            x_pos      <= POS_W'(X_RESET);
            at_left    <= (X_RESET == 0);
            at_right   <= 1'b0;
            speed_fast <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            dir_q      <= dir_nxt;
            x_pos      <= x_nxt;
            at_left    <= (x_nxt == '0);
            at_right   <= (x_nxt == right_limit);
            speed_fast <= (state_nxt == FAST);
        end
    end

    // dir_q remembers the direction being held so a reversal restarts acceleration.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        dir_nxt   = dir_q;
        mv_dir    = DIR_NONE;
        fast_step = 1'b0;
        if (load) begin
            state_nxt = IDLE;
            hold_nxt  = '0;
            dir_nxt   = DIR_NONE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (dir != DIR_NONE) begin
                        state_nxt = SLOW;
                        hold_nxt  = HW'(1);
                        dir_nxt   = dir;
                        mv_dir    = dir;
                    end
                end
                SLOW, FAST: begin
                    if (dir == DIR_NONE) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                        dir_nxt   = DIR_NONE;
                    end else if (dir != dir_q) begin
                        state_nxt = SLOW;
                        hold_nxt  = HW'(1);
                        dir_nxt   = dir;
                        mv_dir    = dir;
                    end else if (state == SLOW) begin
                        hold_nxt = hold + HW'(1);
                        mv_dir   = dir;
                        if (hold_nxt >= HW'(ACCEL_TICKS)) state_nxt = FAST;
                    end else begin
                        mv_dir    = dir;
                        fast_step = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                    dir_nxt   = DIR_NONE;
                end
            endcase
        end
    end

    always_comb begin
        step  = fast_step ? STEP_F : STEP_S;
        sum   = {1'b0, x_pos} + {1'b0, step};
        x_nxt = x_pos;
        if (load) begin
            x_nxt = (x_initial > right_limit) ? right_limit : x_initial;
        end else if (tick) begin
            if (x_pos > right_limit) begin
                x_nxt = right_limit;
            end else if (mv_dir == DIR_LEFT) begin
                x_nxt = (x_pos < step) ? '0 : x_pos - step;
            end else if (mv_dir == DIR_RIGHT) begin
                x_nxt = (sum > {1'b0, right_limit}) ? right_limit : sum[POS_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with TICK_DIV=4, 640-wide field, 100-wide paddle.
module tb_paddle_ctrl;

    logic       clk;
    logic       reset;
    logic       pause;
    logic       load;
    logic [9:0] x_initial;
    logic       move_left;
    logic       move_right;
    logic [9:0] screen_width;
    logic [9:0] paddle_width;
    logic [9:0] x_pos;
    logic       at_left;
    logic       at_right;
    logic       speed_fast;

    int unsigned errors = 0;
    int unsigned checks = 0;

    paddle_ctrl #(
        .POS_W      (10),
        .TICK_DIV   (4),
        .STEP_SLOW  (1),
        .STEP_FAST  (4),
        .ACCEL_TICKS(16),
        .X_RESET    (270)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .load        (load),
        .x_initial   (x_initial),
        .move_left   (move_left),
        .move_right  (move_right),
        .screen_width(screen_width),
        .paddle_width(paddle_width),
        .x_pos       (x_pos),
        .at_left     (at_left),
        .at_right    (at_right),
        .speed_fast  (speed_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int unsigned x, input logic l,
                             input logic r, input logic f);
        check({tag, ".x_pos"}, 32'(x_pos), 32'(x));
        check({tag, ".at_left"}, 32'(at_left), 32'(l));
        check({tag, ".at_right"}, 32'(at_right), 32'(r));
        check({tag, ".speed_fast"}, 32'(speed_fast), 32'(f));
    endtask

    initial begin
        reset        = 1'b0;
        pause        = 1'b0;
        load         = 1'b0;
        x_initial    = '0;
        move_left    = 1'b0;
        move_right   = 1'b0;
        screen_width = 10'd640;
        paddle_width = 10'd100;

        // asynchronous reset, observed before any clock edge
        #3 reset = 1'b1;
        #1 chk_state("reset", 270, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // right held 20 ticks: 16 slow steps, then 4 fast steps
        move_right = 1'b1;
        cyc(4);  chk_state("right_t1", 271, 1'b0, 1'b0, 1'b0);
        cyc(56); chk_state("right_t15", 285, 1'b0, 1'b0, 1'b0);
        cyc(4);  chk_state("right_t16", 286, 1'b0, 1'b0, 1'b1);
        cyc(16); chk_state("right_t20", 302, 1'b0, 1'b0, 1'b1);

        // both directions held = no direction
        move_left = 1'b1;
        cyc(4);  chk_state("both_t1", 302, 1'b0, 1'b0, 1'b0);
        cyc(16); chk_state("both_t5", 302, 1'b0, 1'b0, 1'b0);

        // pause in the middle of a slow run and in the middle of a tick period
        move_left = 1'b0;
        cyc(12); chk_state("slow_h3", 305, 1'b0, 1'b0, 1'b0);
        cyc(2);
        pause = 1'b1;
        cyc(10); chk_state("paused", 305, 1'b0, 1'b0, 1'b0);
        pause = 1'b0;
        cyc(1);  check("resume_no_early", 32'(x_pos), 32'd305);
        cyc(1);  check("resume_tick", 32'(x_pos), 32'd306);
        cyc(44); chk_state("resume_h15", 317, 1'b0, 1'b0, 1'b0);
        cyc(4);  chk_state("resume_h16", 318, 1'b0, 1'b0, 1'b1);

        // load near the right edge, then clamp at right_limit
        x_initial = 10'd538;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk_state("load538", 538, 1'b0, 1'b0, 1'b0);
        cyc(4);  chk_state("right_539", 539, 1'b0, 1'b0, 1'b0);
        cyc(4);  chk_state("right_540", 540, 1'b0, 1'b1, 1'b0);
        cyc(8);  chk_state("right_clamp", 540, 1'b0, 1'b1, 1'b0);

        // accelerate left from 18 down to 2, then a fast step saturates at 0
        move_right = 1'b0;
        move_left  = 1'b1;
        x_initial  = 10'd18;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        check("load18", 32'(x_pos), 32'd18);
        cyc(64); chk_state("left_fast_2", 2, 1'b0, 1'b0, 1'b1);
        cyc(4);  chk_state("left_sat", 0, 1'b1, 1'b0, 1'b1);
        cyc(8);  chk_state("left_hold0", 0, 1'b1, 1'b0, 1'b1);

        // shrinking playfield pulls an out-of-range paddle to right_limit on the next tick
        move_left  = 1'b0;
        x_initial  = 10'd300;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        paddle_width = 10'd700;
        check("load300", 32'(x_pos), 32'd300);
        cyc(3);  check("oversize_wait", 32'(x_pos), 32'd300);
        cyc(1);  chk_state("oversize_tick", 0, 1'b1, 1'b1, 1'b0);

        // load wins over pause and is clamped to right_limit
        paddle_width = 10'd100;
        pause = 1'b1;
        x_initial = 10'd900;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk_state("load900_paused", 540, 1'b0, 1'b1, 1'b0);
        cyc(10); check("load900_hold", 32'(x_pos), 32'd540);
        x_initial = 10'd123;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk_state("load123_paused", 123, 1'b0, 1'b0, 1'b0);
        pause = 1'b0;

        // reset mid-move aborts motion and restarts the tick period
        move_right = 1'b1;
        cyc(6);  check("premove", 32'(x_pos), 32'd124);
        reset = 1'b1;
        #1 chk_state("reset_mid", 270, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(3);  check("post_reset_wait", 32'(x_pos), 32'd270);
        cyc(1);  check("post_reset_tick", 32'(x_pos), 32'd271);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
